// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch (I) and memory-stage (D) requesters, one transaction at a time.
// Optional `MEM_ARB_ROUND_ROBIN_EN alternates grants under contention; default is fixed D-over-I.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ireq_valid,
    input  logic [ADDR_W-1:0]     ireq_addr,
    input  logic [2:0]            ireq_size,
    output logic                  iresp_data_ok,
    output logic [DATA_W-1:0]     iresp_rdata,

    input  logic                  dreq_valid,
    input  logic [ADDR_W-1:0]     dreq_addr,
    input  logic [2:0]            dreq_size,
    input  logic [DATA_W/8-1:0]   dreq_strobe,
    input  logic [DATA_W-1:0]     dreq_wdata,
    output logic                  dresp_data_ok,
    output logic [DATA_W-1:0]     dresp_rdata,

    output logic                  bus_valid,
    output logic                  bus_is_write,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [2:0]            bus_size,
    output logic [DATA_W/8-1:0]   bus_strobe,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ready,
    input  logic [DATA_W-1:0]     bus_rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAITING = 2'd1,
        S_OVER    = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   pick_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // Under contention the port that did not win last time goes first.
    always_comb begin
        pick_d = dreq_valid;
        if (dreq_valid && ireq_valid) begin
            pick_d = (last_grant == OWN_I);
        end
    end
`else
    // Memory stage always wins: it stalls fetch, so serving fetch first could deadlock.
    always_comb begin
        pick_d = dreq_valid;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            owner         <= OWN_I;
            bus_valid     <= 1'b0;
            bus_is_write  <= 1'b0;
            bus_addr      <= '0;
            bus_size      <= '0;
            bus_strobe    <= '0;
            bus_wdata     <= '0;
            iresp_data_ok <= 1'b0;
            iresp_rdata   <= '0;
            dresp_data_ok <= 1'b0;
            dresp_rdata   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant    <= OWN_I;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (ireq_valid || dreq_valid) begin
                        state     <= S_WAITING;
                        bus_valid <= 1'b1;
                        owner     <= pick_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant <= pick_d;
`endif
                        if (pick_d) begin
                            bus_is_write <= |dreq_strobe;
                            bus_addr     <= dreq_addr;
                            bus_size     <= dreq_size;
                            bus_strobe   <= dreq_strobe;
                            bus_wdata    <= dreq_wdata;
                        end else begin
                            bus_is_write <= 1'b0;
                            bus_addr     <= ireq_addr;
                            bus_size     <= ireq_size;
                            bus_strobe   <= STRB_W'(0);
                            bus_wdata    <= DATA_W'(0);
                        end
                    end
                end
                // Bus request is held unchanged until the bus completes; no timeout.
                S_WAITING: begin
                    if (bus_ready) begin
                        state     <= S_OVER;
                        bus_valid <= 1'b0;
                        if (owner == OWN_D) begin
                            dresp_rdata   <= bus_rdata;
                            dresp_data_ok <= 1'b1;
                        end else begin
                            iresp_rdata   <= bus_rdata;
                            iresp_data_ok <= 1'b1;
                        end
                    end
                end
                S_OVER: begin
                    state         <= S_IDLE;
                    iresp_data_ok <= 1'b0;
                    dresp_data_ok <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter: grants and responses are checked by a monitor
// against queued expectations; cycle timing is checked inline by the stimulus.
module tb_mem_bus_arbiter;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                ireq_valid;
    logic [ADDR_W-1:0]   ireq_addr;
    logic [2:0]          ireq_size;
    logic                iresp_data_ok;
    logic [DATA_W-1:0]   iresp_rdata;
    logic                dreq_valid;
    logic [ADDR_W-1:0]   dreq_addr;
    logic [2:0]          dreq_size;
    logic [STRB_W-1:0]   dreq_strobe;
    logic [DATA_W-1:0]   dreq_wdata;
    logic                dresp_data_ok;
    logic [DATA_W-1:0]   dresp_rdata;
    logic                bus_valid;
    logic                bus_is_write;
    logic [ADDR_W-1:0]   bus_addr;
    logic [2:0]          bus_size;
    logic [STRB_W-1:0]   bus_strobe;
    logic [DATA_W-1:0]   bus_wdata;
    logic                bus_ready;
    logic [DATA_W-1:0]   bus_rdata;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .ireq_size     (ireq_size),
        .iresp_data_ok (iresp_data_ok),
        .iresp_rdata   (iresp_rdata),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_wdata    (dreq_wdata),
        .dresp_data_ok (dresp_data_ok),
        .dresp_rdata   (dresp_rdata),
        .bus_valid     (bus_valid),
        .bus_is_write  (bus_is_write),
        .bus_addr      (bus_addr),
        .bus_size      (bus_size),
        .bus_strobe    (bus_strobe),
        .bus_wdata     (bus_wdata),
        .bus_ready     (bus_ready),
        .bus_rdata     (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] wdata;
    } bus_exp_t;

    typedef struct packed {
        logic              port;   // 1 = D, 0 = I
        logic [DATA_W-1:0] rdata;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_i(input logic [ADDR_W-1:0] a, input logic [2:0] s, input logic [DATA_W-1:0] rd);
        bus_q.push_back('{1'b0, a, s, STRB_W'(0), DATA_W'(0)});
        resp_q.push_back('{1'b0, rd});
    endtask

    task automatic push_d(input logic [ADDR_W-1:0] a, input logic [2:0] s, input logic [STRB_W-1:0] st,
                          input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd);
        bus_q.push_back('{|st, a, s, st, wd});
        resp_q.push_back('{1'b1, rd});
    endtask

    // Called in the first bus_valid cycle; bus_ready after 'waits' cycles; returns in the IDLE cycle.
    task automatic finish_txn(input logic port, input logic [DATA_W-1:0] rd, input int waits);
        for (int w = 0; w < waits; w++) begin
            chk("hold_bus_valid", 64'(bus_valid), 64'd1);
            chk("early_data_ok", 64'(iresp_data_ok | dresp_data_ok), 64'd0);
            step();
        end
        chk("ready_cycle_bus_valid", 64'(bus_valid), 64'd1);
        bus_ready = 1'b1;
        bus_rdata = rd;
        step();
        bus_ready = 1'b0;
        bus_rdata = '0;
        chk("over_owner_data_ok", 64'(port ? dresp_data_ok : iresp_data_ok), 64'd1);
        chk("over_other_data_ok", 64'(port ? iresp_data_ok : dresp_data_ok), 64'd0);
        chk("over_bus_valid", 64'(bus_valid), 64'd0);
        step();
        chk("idle_data_ok", 64'(iresp_data_ok | dresp_data_ok), 64'd0);
        chk("idle_bus_valid", 64'(bus_valid), 64'd0);
    endtask

    // Monitor: each new bus grant and each data_ok pulse is matched against the queues.
    logic prev_bv = 1'b0;
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (bus_valid === 1'b1 && prev_bv !== 1'b1) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_grant", 64'(bus_valid), 64'd0);
                end else begin
                    bus_exp_t e;
                    e = bus_q.pop_front();
                    chk("grant_is_write", 64'(bus_is_write), 64'(e.is_write));
                    chk("grant_addr", bus_addr, e.addr);
                    chk("grant_size", 64'(bus_size), 64'(e.size));
                    chk("grant_strobe", 64'(bus_strobe), 64'(e.strobe));
                    chk("grant_wdata", bus_wdata, e.wdata);
                end
            end
            if (iresp_data_ok === 1'b1 || dresp_data_ok === 1'b1) begin
                chk("dual_data_ok", 64'(iresp_data_ok & dresp_data_ok), 64'd0);
                if (resp_q.size() == 0) begin
                    chk("unexpected_data_ok", 64'd1, 64'd0);
                end else begin
                    resp_exp_t r;
                    r = resp_q.pop_front();
                    chk("resp_port", 64'(dresp_data_ok), 64'(r.port));
                    chk("resp_rdata", r.port ? dresp_rdata : iresp_rdata, r.rdata);
                end
            end
        end
        prev_bv = bus_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rr_order [4];
        reset       = 1'b1;
        ireq_valid  = 1'b0; ireq_addr = '0; ireq_size = '0;
        dreq_valid  = 1'b0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_wdata = '0;
        bus_ready   = 1'b0; bus_rdata = '0;

        // Reset held with both requests pending.
        ireq_valid = 1'b1; ireq_addr = 64'h100; ireq_size = 3'd3;
        dreq_valid = 1'b1; dreq_addr = 64'h200; dreq_size = 3'd3; dreq_strobe = 8'h0F; dreq_wdata = 64'h55;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_bus_valid", 64'(bus_valid), 64'd0);
            chk("rst_data_ok", 64'(iresp_data_ok | dresp_data_ok), 64'd0);
            chk("rst_bus_addr", bus_addr, 64'd0);
            chk("rst_bus_wdata", bus_wdata, 64'd0);
        end
        reset = 1'b0;
        chk("post_rst_bus_valid0", 64'(bus_valid), 64'd0);
        push_d(64'h200, 3'd3, 8'h0F, 64'h55, 64'hAA);
        push_i(64'h100, 3'd3, 64'hBB);
        step();
        chk("post_rst_bus_valid1", 64'(bus_valid), 64'd1);
        finish_txn(1'b1, 64'hAA, 0);
        dreq_valid = 1'b0;
        step();
        finish_txn(1'b0, 64'hBB, 0);
        ireq_valid = 1'b0;
        step();
        chk("quiet_bus_valid", 64'(bus_valid), 64'd0);

        // Single fetch, bus_ready at cycle 3.
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0000; ireq_size = 3'd2;
        push_i(64'h8000_0000, 3'd2, 64'h13);
        step();
        chk("fetch_is_write", 64'(bus_is_write), 64'd0);
        chk("fetch_strobe", 64'(bus_strobe), 64'd0);
        finish_txn(1'b0, 64'h13, 2);
        ireq_valid = 1'b0;
        step();
        chk("fetch_no_regrant", 64'(bus_valid), 64'd0);

        // Contention: store wins, fetch follows at cycle 5.
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0004; ireq_size = 3'd2;
        dreq_valid = 1'b1; dreq_addr = 64'h8000_1000; dreq_size = 3'd3;
        dreq_strobe = 8'hFF; dreq_wdata = 64'hDEAD_BEEF;
        push_d(64'h8000_1000, 3'd3, 8'hFF, 64'hDEAD_BEEF, 64'h0);
        push_i(64'h8000_0004, 3'd2, 64'h1234);
        step();
        chk("cont_store_first", 64'(bus_is_write), 64'd1);
        finish_txn(1'b1, 64'h0, 1);
        dreq_valid = 1'b0; dreq_strobe = '0;
        step();
        chk("cont_fetch_cycle5", 64'(bus_valid), 64'd1);
        chk("cont_fetch_read", 64'(bus_is_write), 64'd0);
        finish_txn(1'b0, 64'h1234, 0);
        ireq_valid = 1'b0;
        step();

        // Four grants with both ports continuously valid.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_order[0] = 1'b1; rr_order[1] = 1'b0; rr_order[2] = 1'b1; rr_order[3] = 1'b0;
`else
        rr_order[0] = 1'b1; rr_order[1] = 1'b1; rr_order[2] = 1'b1; rr_order[3] = 1'b1;
`endif
        ireq_valid = 1'b1; ireq_addr = 64'h9000; ireq_size = 3'd2;
        dreq_valid = 1'b1; dreq_addr = 64'hA000; dreq_size = 3'd3; dreq_strobe = 8'h00; dreq_wdata = 64'h0;
        for (int g = 0; g < 4; g++) begin
            if (rr_order[g]) push_d(64'hA000, 3'd3, 8'h00, 64'h0, 64'(32'hD00 + g));
            else             push_i(64'h9000, 3'd2, 64'(32'h100 + g));
        end
        for (int g = 0; g < 4; g++) begin
            step();
            chk("rr_bus_valid", 64'(bus_valid), 64'd1);
            finish_txn(rr_order[g], rr_order[g] ? 64'(32'hD00 + g) : 64'(32'h100 + g), 0);
        end
        ireq_valid = 1'b0; dreq_valid = 1'b0;
        step();
        chk("rr_quiet", 64'(bus_valid), 64'd0);

        // Reset while WAITING on a store.
        dreq_valid = 1'b1; dreq_addr = 64'h3000; dreq_size = 3'd0; dreq_strobe = 8'h01; dreq_wdata = 64'h77;
        bus_q.push_back('{1'b1, 64'h3000, 3'd0, 8'h01, 64'h77});
        step();
        chk("rstw_granted", 64'(bus_valid), 64'd1);
        step();
        step();
        reset = 1'b1;
        step();
        chk("rstw_bus_valid", 64'(bus_valid), 64'd0);
        chk("rstw_no_dresp", 64'(dresp_data_ok), 64'd0);
        reset = 1'b0; dreq_valid = 1'b0; dreq_strobe = '0;
        ireq_valid = 1'b1; ireq_addr = 64'h4000; ireq_size = 3'd2;
        push_i(64'h4000, 3'd2, 64'h4444);
        step();
        chk("rstw_fetch_grant", 64'(bus_valid), 64'd1);
        finish_txn(1'b0, 64'h4444, 1);
        ireq_valid = 1'b0;
        step();

        // Zero-wait bus with request held across completion.
        ireq_valid = 1'b1; ireq_addr = 64'h5000; ireq_size = 3'd2;
        push_i(64'h5000, 3'd2, 64'h51);
        push_i(64'h5000, 3'd2, 64'h52);
        step();
        finish_txn(1'b0, 64'h51, 0);
        step();
        chk("zw_regrant_cycle4", 64'(bus_valid), 64'd1);
        finish_txn(1'b0, 64'h52, 0);
        ireq_valid = 1'b0;
        step();
        step();

        chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
        chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
